// File: rtl/layer_input_fetch_if.sv
// Bundle of the fetch unit's control, RAM read port and CNN data stream.
// master = the fetch unit, slave = the surrounding system (controller, RAM, CNN).
interface layer_input_fetch_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          Start;
    logic [AW-1:0] BaseAddress;
    logic [15:0]   WordCount;
    logic          Layer;
    logic [AW-1:0] AddressLayerInput;
    logic          RamReadEn;
    logic [DW-1:0] RamData;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          DataReady;
    logic          Busy;
    logic          Done;

    modport master (
        input  Start, BaseAddress, WordCount, RamData, DataReady,
        output Layer, AddressLayerInput, RamReadEn, DataOut, DataValid, Busy, Done
    );

    modport slave (
        output Start, BaseAddress, WordCount, RamData, DataReady,
        input  Layer, AddressLayerInput, RamReadEn, DataOut, DataValid, Busy, Done
    );
endinterface

// File: rtl/layer_input_fetch.sv
// Streams WordCount words from RAM starting at BaseAddress into a small FIFO
// feeding the CNN; reads are throttled so the FIFO can never overflow.
module layer_input_fetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    layer_input_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    state_t        state, stateNext;
    logic [AW-1:0] addr;
    logic [15:0]   remaining;
    logic          inFlight;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          issue, push, pop, empty;

    assign empty     = (count == '0);
    assign occupancy = count + CW'(inFlight);
    // RAM latency is one cycle, so the read strobe delayed once marks valid RamData
    assign push      = inFlight;
    assign pop       = !empty && bus.DataReady;

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start)
                    stateNext = (bus.WordCount == 16'd0) ? FINISH : FETCH;
            end
            FETCH: begin
                if (occupancy < DEPTH_C) begin
                    issue = 1'b1;
                    if (remaining == 16'd1)
                        stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!inFlight && empty)
                    stateNext = FINISH;
            end
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Address only moves on a real fetch start or an issued read, so it stays put while RamReadEn is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            inFlight  <= 1'b0;
        end else begin
            inFlight <= issue;
            if (state == IDLE && bus.Start && bus.WordCount != 16'd0) begin
                addr      <= bus.BaseAddress;
                remaining <= bus.WordCount;
            end else if (issue) begin
                addr      <= addr + AW'(1);
                remaining <= remaining - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= bus.RamData;
    end

    assign bus.AddressLayerInput = addr;
    assign bus.RamReadEn         = issue;
    assign bus.DataValid         = !empty;
    assign bus.DataOut           = empty ? '0 : mem[rdPtr];
    assign bus.Layer             = (state != IDLE);
    assign bus.Busy              = (state != IDLE);
    assign bus.Done              = (state == FINISH);
endmodule

// File: tb/tb_layer_input_fetch.sv
// Directed bench for layer_input_fetch: RAM responder, negedge monitor and one task per scenario.
module tb_layer_input_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   startCyc = 0;
    int   doneCnt = 0;
    int   doneCyc = 0;
    int   validSeen = 0;
    logic [15:0] addrQ[$];
    int          cycQ[$];
    logic [15:0] outQ[$];

    always #5 clk = ~clk;

    layer_input_fetch_if #(.AW(16), .DW(16)) bus();

    layer_input_fetch #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // RAM responder: data is a fixed function of the address, garbage when not read
    always @(posedge clk)
        bus.RamData <= bus.RamReadEn ? (bus.AddressLayerInput ^ 16'hA5A5) : 16'hDEAD;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.RamReadEn) begin
                addrQ.push_back(bus.AddressLayerInput);
                cycQ.push_back(cyc);
            end
            if (bus.DataValid && bus.DataReady) outQ.push_back(bus.DataOut);
            if (bus.DataValid) validSeen++;
            if (bus.Done) begin
                doneCnt++;
                doneCyc = cyc;
            end
        end
    end

    task automatic clearMon();
        addrQ.delete();
        cycQ.delete();
        outQ.delete();
        doneCnt = 0;
        validSeen = 0;
    endtask

    task automatic doStart(input logic [15:0] base, input logic [15:0] cnt);
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.BaseAddress = base;
        bus.WordCount = cnt;
        @(posedge clk); #1;
        startCyc = cyc;
        bus.Start = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk); #1;
            if (doneCnt != 0 && !bus.Busy) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.Start = 1'b0;
        bus.BaseAddress = 16'h0;
        bus.WordCount = 16'h0;
        bus.DataReady = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.RamReadEn !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", bus.RamReadEn); end
        checks++; if (bus.AddressLayerInput !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.AddressLayerInput); end
        checks++; if ({bus.Layer, bus.Busy, bus.Done, bus.DataValid} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {bus.Layer, bus.Busy, bus.Done, bus.DataValid}); end
        checks++; if (bus.DataOut !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0000", bus.DataOut); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        clearMon();
        bus.DataReady = 1'b1;
        doStart(16'h0010, 16'd5);
        waitDone(60, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got busy want done"); end
        checks++; if (addrQ.size() !== 5) begin errors++; $display("FAIL basic_nreads got %0d want 5", addrQ.size()); end
        checks++; if (outQ.size() !== 5) begin errors++; $display("FAIL basic_nwords got %0d want 5", outQ.size()); end
        for (int i = 0; i < 5 && i < addrQ.size(); i++) begin
            checks++; if (addrQ[i] !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, addrQ[i], 16'h0010 + 16'(i)); end
            checks++; if (cycQ[i] !== startCyc + i) begin errors++; $display("FAIL basic_rdcyc[%0d] got %0d want %0d", i, cycQ[i], startCyc + i); end
        end
        for (int i = 0; i < 5 && i < outQ.size(); i++) begin
            checks++; if (outQ[i] !== ((16'h0010 + 16'(i)) ^ 16'hA5A5)) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, outQ[i], (16'h0010 + 16'(i)) ^ 16'hA5A5); end
        end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", doneCnt); end
        checks++; if (bus.Layer !== 1'b0) begin errors++; $display("FAIL basic_layer got %b want 0", bus.Layer); end
    endtask

    task automatic test_wrap();
        bit to;
        logic [15:0] expA [4];
        expA[0] = 16'hFFFE; expA[1] = 16'hFFFF; expA[2] = 16'h0000; expA[3] = 16'h0001;
        clearMon();
        bus.DataReady = 1'b1;
        doStart(16'hFFFE, 16'd4);
        waitDone(60, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout got busy want done"); end
        checks++; if (addrQ.size() !== 4) begin errors++; $display("FAIL wrap_nreads got %0d want 4", addrQ.size()); end
        for (int i = 0; i < 4 && i < addrQ.size(); i++) begin
            checks++; if (addrQ[i] !== expA[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, addrQ[i], expA[i]); end
        end
        for (int i = 0; i < 4 && i < outQ.size(); i++) begin
            checks++; if (outQ[i] !== (expA[i] ^ 16'hA5A5)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, outQ[i], expA[i] ^ 16'hA5A5); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        clearMon();
        bus.DataReady = 1'b0;
        doStart(16'h0200, 16'd8);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (addrQ.size() !== 4) begin errors++; $display("FAIL bp_stall_reads got %0d want 4", addrQ.size()); end
        checks++; if (bus.RamReadEn !== 1'b0) begin errors++; $display("FAIL bp_stall_rden got %b want 0", bus.RamReadEn); end
        checks++; if (bus.DataOut !== (16'h0200 ^ 16'hA5A5)) begin errors++; $display("FAIL bp_head got %h want %h", bus.DataOut, 16'h0200 ^ 16'hA5A5); end
        @(posedge clk); #1;
        bus.DataReady = 1'b1;
        waitDone(80, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got busy want done"); end
        checks++; if (addrQ.size() !== 8) begin errors++; $display("FAIL bp_nreads got %0d want 8", addrQ.size()); end
        checks++; if (outQ.size() !== 8) begin errors++; $display("FAIL bp_nwords got %0d want 8", outQ.size()); end
        for (int i = 0; i < 8 && i < outQ.size(); i++) begin
            checks++; if (outQ[i] !== ((16'h0200 + 16'(i)) ^ 16'hA5A5)) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", i, outQ[i], (16'h0200 + 16'(i)) ^ 16'hA5A5); end
        end
    endtask

    task automatic test_zero_count();
        bit to;
        clearMon();
        bus.DataReady = 1'b1;
        doStart(16'h0300, 16'd0);
        waitDone(10, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout got busy want done"); end
        checks++; if (addrQ.size() !== 0) begin errors++; $display("FAIL zero_reads got %0d want 0", addrQ.size()); end
        checks++; if (doneCnt !== 1 || doneCyc - startCyc > 2) begin errors++; $display("FAIL zero_done got cnt %0d lat %0d want cnt 1 lat<=2", doneCnt, doneCyc - startCyc); end
        checks++; if (validSeen !== 0) begin errors++; $display("FAIL zero_valid got %0d want 0", validSeen); end
    endtask

    task automatic test_start_ignored();
        bit to;
        clearMon();
        bus.DataReady = 1'b1;
        doStart(16'h0400, 16'd6);
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.BaseAddress = 16'h0800;
        bus.WordCount = 16'd3;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        waitDone(60, to);
        checks++; if (to) begin errors++; $display("FAIL ign_timeout got busy want done"); end
        checks++; if (addrQ.size() !== 6) begin errors++; $display("FAIL ign_nreads got %0d want 6", addrQ.size()); end
        checks++; if (outQ.size() !== 6) begin errors++; $display("FAIL ign_nwords got %0d want 6", outQ.size()); end
        for (int i = 0; i < 6 && i < addrQ.size(); i++) begin
            checks++; if (addrQ[i] !== 16'h0400 + 16'(i)) begin errors++; $display("FAIL ign_addr[%0d] got %h want %h", i, addrQ[i], 16'h0400 + 16'(i)); end
        end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL ign_done got %0d want 1", doneCnt); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen3;
        clearMon();
        bus.DataReady = 1'b0;
        doStart(16'h0500, 16'd10);
        seen3 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (addrQ.size() >= 3) begin
                seen3 = 1'b1;
                break;
            end
        end
        checks++; if (!seen3 || addrQ.size() !== 3) begin errors++; $display("FAIL rst_pre_reads got %0d want 3", addrQ.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.Layer, bus.Busy, bus.Done, bus.DataValid, bus.RamReadEn} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags got %b want 00000", {bus.Layer, bus.Busy, bus.Done, bus.DataValid, bus.RamReadEn}); end
        checks++; if (bus.DataOut !== 16'h0 || bus.AddressLayerInput !== 16'h0) begin errors++; $display("FAIL rst_mid_bus got dout %h addr %h want 0000 0000", bus.DataOut, bus.AddressLayerInput); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clearMon();
        bus.DataReady = 1'b1;
        doStart(16'h0100, 16'd2);
        waitDone(40, to);
        checks++; if (to) begin errors++; $display("FAIL rst_new_timeout got busy want done"); end
        checks++; if (addrQ.size() !== 2) begin errors++; $display("FAIL rst_new_nreads got %0d want 2", addrQ.size()); end
        checks++; if (outQ.size() !== 2) begin errors++; $display("FAIL rst_new_nwords got %0d want 2", outQ.size()); end
        for (int i = 0; i < 2 && i < outQ.size(); i++) begin
            checks++; if (outQ[i] !== ((16'h0100 + 16'(i)) ^ 16'hA5A5)) begin errors++; $display("FAIL rst_new_data[%0d] got %h want %h", i, outQ[i], (16'h0100 + 16'(i)) ^ 16'hA5A5); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
